mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, the maximum number of WAIT cycles before a data-memory access is aborted.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 memAluResultIn  in  32  EX/MEM ALU result, also the memory address.
REQ-005 memStoreDataIn  in  32  EX/MEM store data.
REQ-006 memRdIn  in  5  EX/MEM destination register.
REQ-007 memRegWriteIn, memMemWriteIn, memMemReadIn, memMemToRegIn  in  1 each  EX/MEM control bits.
REQ-008 dmemReq, dmemWe  out  1 each  memory request and write enable.
REQ-009 dmemAddr, dmemWdata  out  32 each  memory address and write data.
REQ-010 dmemRdata  in  32, dmemAck  in  1  read data and completion acknowledge.
REQ-011 memStall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
REQ-012 memBusErr  out  1  one-cycle pulse on access timeout.
REQ-013 memwbRegWriteOut, memwbMemToRegOut  out  1 each  registered MEM/WB control bits.
REQ-014 memwbReadDataOut, memwbAluResultOut  out  32 each  registered MEM/WB data.
REQ-015 memwbRdOut  out  5  registered MEM/WB destination register.

Function
REQ-016 memOp SHALL be memMemReadIn OR memMemWriteIn; when both are set the access SHALL be a write.
REQ-017 The FSM SHALL have two states, IDLE and WAIT.
REQ-018 dmemReq SHALL be 1 combinationally in IDLE when memOp=1, and in WAIT.
REQ-019 dmemWe SHALL equal memMemWriteIn; dmemAddr SHALL equal memAluResultIn; dmemWdata SHALL equal memStoreDataIn.
REQ-020 memStall SHALL be dmemReq AND NOT dmemAck AND NOT timeout.
REQ-021 IDLE with memOp=1 and dmemAck=1 SHALL complete in that cycle, with no stall and FSM staying IDLE.
REQ-022 IDLE with memOp=1 and dmemAck=0 SHALL go to WAIT and clear the wait counter.
REQ-023 In WAIT the counter SHALL increment each cycle; timeout SHALL be asserted when counter = TIMEOUT_CYCLES-1 and dmemAck=0.
REQ-024 In WAIT, dmemAck=1 SHALL complete the access and return to IDLE; dmemAck and timeout in the same cycle SHALL resolve as ack.
REQ-025 On timeout the FSM SHALL return to IDLE and pulse memBusErr for one cycle, and MEM/WB SHALL load a bubble.
REQ-026 The MEM/WB register SHALL load on every edge.
REQ-027 MEM/WB loading SHALL take one of three forms:
- completing cycle or non-memory op: inputs, with memwbReadDataOut = dmemRdata on reads, else unchanged;
- memStall=1: bubble, with memwbRegWriteOut = 0 and memwbMemToRegOut = 0;
- timeout: bubble, as above.
REQ-028 Latency SHALL be 1 cycle for non-memory ops and N+1 cycles for an access acked N cycles after its first request.
REQ-029 dmemAck while dmemReq=0 SHALL be ignored.
REQ-030 Upstream SHALL hold EX/MEM inputs stable while memStall=1; the block SHALL NOT latch them.

Reset
REQ-031 rst=0 SHALL asynchronously force:
- state IDLE and counter 0;
- memBusErr, memwbRegWriteOut and memwbMemToRegOut to 0;
- all MEM/WB data fields to 0.
REQ-032 Reset during WAIT SHALL drop dmemReq and memStall at once, with no MEM/WB write.

Configuration
REQ-033 Macro MEM_ALIGN_CHECK_EN, when defined, SHALL add output memAlignErr (1 bit, registered, one-cycle pulse).
REQ-034 With MEM_ALIGN_CHECK_EN defined, memOp=1 with memAluResultIn[1:0]!=0 SHALL suppress dmemReq, pulse memAlignErr and load a MEM/WB bubble.
REQ-035 Without MEM_ALIGN_CHECK_EN, the port SHALL be absent and addr[1:0] SHALL be passed unchecked.

Verification
REQ-036 Add, rd=5, ALU=0x10 -> next edge: memwbRegWriteOut=1, memwbRdOut=5, memwbAluResultOut=0x10, memStall=0.
REQ-037 lw addr 0x40, ack same cycle, rdata=0xDEADBEEF -> no stall; next edge: memwbReadDataOut=0xDEADBEEF, memwbMemToRegOut=1.
REQ-038 sw addr 0x44, ack after 3 cycles -> memStall=1 for exactly 3 cycles, dmemWe=1 throughout, bubbles in MEM/WB, then one store completes.
REQ-039 lw, never acked, TIMEOUT_CYCLES=4 -> stall for 1+3 cycles, then memBusErr for 1 cycle, bubble, FSM IDLE.
REQ-040 rst low during WAIT -> dmemReq=0 immediately; after release, next lw completes normally.
REQ-041 MEM_ALIGN_CHECK_EN defined, lw addr 0x42 -> dmemReq=0, memAlignErr=1 for 1 cycle, memwbRegWriteOut=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with data-memory handshake, bounded wait timeout and MEM/WB register.
// Optional misaligned-access trap is compiled in when MEM_ALIGN_CHECK_EN is defined.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] memAluResultIn,
  input  logic [31:0] memStoreDataIn,
  input  logic [4:0]  memRdIn,
  input  logic        memRegWriteIn,
  input  logic        memMemWriteIn,
  input  logic        memMemReadIn,
  input  logic        memMemToRegIn,
  output logic        dmemReq,
  output logic        dmemWe,
  output logic [31:0] dmemAddr,
  output logic [31:0] dmemWdata,
  input  logic [31:0] dmemRdata,
  input  logic        dmemAck,
  output logic        memStall,
  output logic        memBusErr,
  output logic        memwbRegWriteOut,
  output logic        memwbMemToRegOut,
  output logic [31:0] memwbReadDataOut,
  output logic [31:0] memwbAluResultOut,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        memAlignErr,
`endif
  output logic [4:0]  memwbRdOut
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic        r_bus_err;
  logic        r_regwrite;
  logic        r_memtoreg;
  logic [31:0] r_rdata;
  logic [31:0] r_alu;
  logic [4:0]  r_rd;

  logic w_mem_op;
  logic w_is_read;
  logic w_misalign;
  logic w_req;
  logic w_timeout;
  logic w_complete;

  assign w_mem_op  = memMemReadIn | memMemWriteIn;
  assign w_is_read = memMemReadIn & ~memMemWriteIn;

`ifdef MEM_ALIGN_CHECK_EN
  logic r_align_err;
  assign w_misalign  = w_mem_op & (memAluResultIn[1:0] != 2'b00);
  assign memAlignErr = r_align_err;
`else
  assign w_misalign  = 1'b0;
`endif

  // Gated by rst so an async reset mid-access drops the request in the same instant.
  assign w_req = rst & (((r_state == S_IDLE) & w_mem_op & ~w_misalign) | (r_state == S_WAIT));

  assign w_timeout  = (r_state == S_WAIT) & (r_cnt == TC_LAST) & ~dmemAck;
  assign w_complete = ~w_mem_op | (w_req & dmemAck);

  assign dmemReq   = w_req;
  assign dmemWe    = memMemWriteIn;
  assign dmemAddr  = memAluResultIn;
  assign dmemWdata = memStoreDataIn;
  assign memStall  = w_req & ~dmemAck & ~w_timeout;

  assign memBusErr         = r_bus_err;
  assign memwbRegWriteOut  = r_regwrite;
  assign memwbMemToRegOut  = r_memtoreg;
  assign memwbReadDataOut  = r_rdata;
  assign memwbAluResultOut = r_alu;
  assign memwbRdOut        = r_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bus_err  <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_rdata    <= '0;
      r_alu      <= '0;
      r_rd       <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      r_align_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && !dmemAck) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (dmemAck || w_timeout) r_state <= S_IDLE;
          else                      r_cnt   <= r_cnt + CW'(1);
        end
        default: r_state <= S_IDLE;
      endcase

      r_bus_err <= w_timeout;
`ifdef MEM_ALIGN_CHECK_EN
      r_align_err <= w_misalign;
`endif

      // Stall, timeout and alignment traps all fall to the bubble branch.
      if (w_complete) begin
        r_regwrite <= memRegWriteIn;
        r_memtoreg <= memMemToRegIn;
        r_alu      <= memAluResultIn;
        r_rd       <= memRdIn;
        if (w_is_read) r_rdata <= dmemRdata;
      end else begin
        r_regwrite <= 1'b0;
        r_memtoreg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a transaction-level model.
// Runs with TIMEOUT_CYCLES=4; the alignment check is exercised only when MEM_ALIGN_CHECK_EN is defined.
module tb_mem_stage;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] memAluResultIn = '0;
  logic [31:0] memStoreDataIn = '0;
  logic [4:0]  memRdIn = '0;
  logic        memRegWriteIn = 1'b0;
  logic        memMemWriteIn = 1'b0;
  logic        memMemReadIn = 1'b0;
  logic        memMemToRegIn = 1'b0;
  logic        dmemReq, dmemWe;
  logic [31:0] dmemAddr, dmemWdata;
  logic [31:0] dmemRdata = '0;
  logic        dmemAck = 1'b0;
  logic        memStall, memBusErr;
  logic        memwbRegWriteOut, memwbMemToRegOut;
  logic [31:0] memwbReadDataOut, memwbAluResultOut;
  logic [4:0]  memwbRdOut;
`ifdef MEM_ALIGN_CHECK_EN
  logic        memAlignErr;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_rdata = '0;

  mem_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .memAluResultIn(memAluResultIn), .memStoreDataIn(memStoreDataIn), .memRdIn(memRdIn),
    .memRegWriteIn(memRegWriteIn), .memMemWriteIn(memMemWriteIn),
    .memMemReadIn(memMemReadIn), .memMemToRegIn(memMemToRegIn),
    .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemWdata(dmemWdata),
    .dmemRdata(dmemRdata), .dmemAck(dmemAck),
    .memStall(memStall), .memBusErr(memBusErr),
    .memwbRegWriteOut(memwbRegWriteOut), .memwbMemToRegOut(memwbMemToRegOut),
    .memwbReadDataOut(memwbReadDataOut), .memwbAluResultOut(memwbAluResultOut),
`ifdef MEM_ALIGN_CHECK_EN
    .memAlignErr(memAlignErr),
`endif
    .memwbRdOut(memwbRdOut)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One instruction through MEM. Called just after a rising edge.
  // n_ack = cycles after first request at which ack arrives; n_ack > T never acks in time.
  task automatic do_op(input logic rw, input logic mr, input logic mw, input logic m2r,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                       input logic [31:0] rdata, input int n_ack, input logic stray_ack);
    int last;
    logic tmo;
    memRegWriteIn = rw; memMemReadIn = mr; memMemWriteIn = mw; memMemToRegIn = m2r;
    memAluResultIn = alu; memStoreDataIn = sd; memRdIn = rd;
    if (!(mr | mw)) begin
      @(negedge clk);
      dmemAck = stray_ack; dmemRdata = $urandom;
      #1;
      chk("req_nomem", dmemReq, 0);
      chk("stall_nomem", memStall, 0);
      @(posedge clk); #1;
      chk("wb_regwrite", memwbRegWriteOut, rw);
      chk("wb_memtoreg", memwbMemToRegOut, m2r);
      chk("wb_alu", memwbAluResultOut, alu);
      chk("wb_rd", memwbRdOut, rd);
      chk("wb_rdata_hold", memwbReadDataOut, exp_rdata);
      chk("buserr_nomem", memBusErr, 0);
    end else begin
      tmo  = (n_ack > T);
      last = tmo ? T : n_ack;
      for (int k = 0; k <= last; k++) begin
        @(negedge clk);
        dmemAck   = (k == n_ack);
        dmemRdata = (k == n_ack) ? rdata : $urandom;
        #1;
        chk("req", dmemReq, 1);
        chk("we", dmemWe, mw);
        chk("addr", dmemAddr, alu);
        chk("wdata", dmemWdata, sd);
        chk("stall", memStall, (k < last));
        @(posedge clk); #1;
        if (k < last) begin
          chk("bubble_regwrite", memwbRegWriteOut, 0);
          chk("bubble_memtoreg", memwbMemToRegOut, 0);
          chk("buserr_wait", memBusErr, 0);
        end
      end
      if (tmo) begin
        chk("tmo_buserr", memBusErr, 1);
        chk("tmo_regwrite", memwbRegWriteOut, 0);
        chk("tmo_memtoreg", memwbMemToRegOut, 0);
      end else begin
        if (mr && !mw) exp_rdata = rdata;
        chk("done_regwrite", memwbRegWriteOut, rw);
        chk("done_memtoreg", memwbMemToRegOut, m2r);
        chk("done_alu", memwbAluResultOut, alu);
        chk("done_rd", memwbRdOut, rd);
        chk("done_rdata", memwbReadDataOut, exp_rdata);
        chk("done_buserr", memBusErr, 0);
      end
    end
    dmemAck = 1'b0;
  endtask

  initial begin
    logic [31:0] a, d, r;
    int kind;
    #2 rst = 1'b0;
    #1;
    chk("rst_regwrite", memwbRegWriteOut, 0);
    chk("rst_memtoreg", memwbMemToRegOut, 0);
    chk("rst_rdata", memwbReadDataOut, 0);
    chk("rst_alu", memwbAluResultOut, 0);
    chk("rst_rd", memwbRdOut, 0);
    chk("rst_buserr", memBusErr, 0);
    chk("rst_req", dmemReq, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    do_op(1, 0, 0, 0, 32'h10, 32'h0, 5'd5, 32'h0, 0, 0);               // add
    do_op(1, 1, 0, 1, 32'h40, 32'h0, 5'd7, 32'hDEADBEEF, 0, 0);        // lw, immediate ack
    do_op(0, 0, 1, 0, 32'h44, 32'hCAFEF00D, 5'd0, 32'h0, 3, 0);        // sw, ack after 3
    do_op(1, 1, 0, 1, 32'h48, 32'h0, 5'd9, 32'h0, 99, 0);              // lw, never acked
    do_op(1, 0, 0, 0, 32'h5, 32'h0, 5'd3, 32'h0, 0, 1);                // stray ack ignored
    do_op(1, 1, 0, 1, 32'h4C, 32'h0, 5'd10, 32'h12345678, T, 0);       // ack with timeout
    do_op(0, 1, 1, 0, 32'h50, 32'h11112222, 5'd11, 32'hFFFF0000, 1, 0); // read+write is a write

    // Reset while waiting on an access.
    memRegWriteIn = 1; memMemReadIn = 1; memMemWriteIn = 0; memMemToRegIn = 1;
    memAluResultIn = 32'h60; memRdIn = 5'd12;
    @(negedge clk); #1;
    chk("pre_rst_stall", memStall, 1);
    @(posedge clk); #1;
    chk("pre_rst_stall2", memStall, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_wait_req", dmemReq, 0);
    chk("rst_wait_stall", memStall, 0);
    chk("rst_wait_regwrite", memwbRegWriteOut, 0);
    chk("rst_wait_rdata", memwbReadDataOut, 0);
    exp_rdata = '0;
    memMemReadIn = 0; memRegWriteIn = 0; memMemToRegIn = 0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    do_op(1, 1, 0, 1, 32'h64, 32'h0, 5'd13, 32'hA5A5A5A5, 2, 0);

`ifdef MEM_ALIGN_CHECK_EN
    memRegWriteIn = 1; memMemReadIn = 1; memMemWriteIn = 0; memMemToRegIn = 1;
    memAluResultIn = 32'h42; memRdIn = 5'd14;
    @(negedge clk); #1;
    chk("align_req", dmemReq, 0);
    chk("align_stall", memStall, 0);
    @(posedge clk); #1;
    chk("align_err", memAlignErr, 1);
    chk("align_regwrite", memwbRegWriteOut, 0);
    memMemReadIn = 0; memRegWriteIn = 0; memMemToRegIn = 0;
    @(posedge clk); #1;
    chk("align_err_pulse", memAlignErr, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      a = $urandom; a[1:0] = 2'b00;
      d = $urandom; r = $urandom;
      do_op(1'($urandom_range(0, 1)), (kind == 1 || kind == 3), (kind == 2 || kind == 3),
            1'($urandom_range(0, 1)), a, d, 5'($urandom_range(0, 31)), r,
            $urandom_range(0, T + 2), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
